// File: rtl/smc_pkg.sv
// Shared types and defaults for the slot-memory-controller endpoint lookup.
package smc_pkg;

   localparam int SMC_NUM_SLOTS_DEF = 16;
   localparam int SMC_EP_W_DEF      = 8;

   // Reference layouts at default width; modules rebuild them with their own EP_W.
   typedef struct packed {
      logic                    valid;
      logic [SMC_EP_W_DEF-1:0] ep_id;
   } ep_lookup_t;

   typedef struct packed {
      logic                    valid;
      logic [SMC_EP_W_DEF-1:0] ep_id;
   } slot_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_RESP = 2'd2
   } smc_state_e;

endpackage

// File: rtl/smc_slot_table.sv
// Slot table: NUM_SLOTS {valid, ep_id} registers, one sync write port,
// one combinational read port, cleared by synchronous reset.
module smc_slot_table
   import smc_pkg::*;
#(
   parameter  int NUM_SLOTS  = SMC_NUM_SLOTS_DEF,
   parameter  int EP_W       = SMC_EP_W_DEF,
   localparam int SLOT_IDX_W = $clog2(NUM_SLOTS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [SLOT_IDX_W-1:0] wr_idx_i,
   input  logic                  wr_valid_i,
   input  logic [EP_W-1:0]       wr_ep_id_i,
   input  logic [SLOT_IDX_W-1:0] rd_idx_i,
   output logic                  rd_valid_o,
   output logic [EP_W-1:0]       rd_ep_id_o
);

   typedef struct packed {
      logic            valid;
      logic [EP_W-1:0] ep_id;
   } entry_t;

   entry_t [NUM_SLOTS-1:0] tbl_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         tbl_q <= '0;
      end else if (we_i) begin
         tbl_q[wr_idx_i] <= '{valid: wr_valid_i, ep_id: wr_ep_id_i};
      end
   end

   // Read sees the registered value, so a same-cycle write is not visible yet.
   assign rd_valid_o = tbl_q[rd_idx_i].valid;
   assign rd_ep_id_o = tbl_q[rd_idx_i].ep_id;

endmodule

// File: rtl/smc_slot_responder.sv
// Endpoint-lookup responder: sequentially scans the slot table for the lowest
// valid slot bound to the requested endpoint and returns hit + slot index.
module smc_slot_responder
   import smc_pkg::*;
#(
   parameter  int NUM_SLOTS  = SMC_NUM_SLOTS_DEF,
   parameter  int EP_W       = SMC_EP_W_DEF,
   localparam int SLOT_IDX_W = $clog2(NUM_SLOTS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [EP_W-1:0]       req_ep_id,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_hit,
   output logic [SLOT_IDX_W-1:0] rsp_slot,
   input  logic                  cfg_we,
   input  logic [SLOT_IDX_W-1:0] cfg_slot,
   input  logic [EP_W-1:0]       cfg_ep_id,
   input  logic                  cfg_valid
);

   localparam logic [SLOT_IDX_W-1:0] LAST_IDX = SLOT_IDX_W'(NUM_SLOTS - 1);

   smc_state_e            state_q, state_d;
   logic [SLOT_IDX_W-1:0] idx_q,   idx_d;
   logic [EP_W-1:0]       ep_q,    ep_d;
   logic                  hit_q,   hit_d;
   logic [SLOT_IDX_W-1:0] slot_q,  slot_d;

   logic                  tbl_valid;
   logic [EP_W-1:0]       tbl_ep_id;

   smc_slot_table #(
      .NUM_SLOTS (NUM_SLOTS),
      .EP_W      (EP_W)
   ) u_table (
      .clk        (clk),
      .rst        (rst),
      .we_i       (cfg_we),
      .wr_idx_i   (cfg_slot),
      .wr_valid_i (cfg_valid),
      .wr_ep_id_i (cfg_ep_id),
      .rd_idx_i   (idx_q),
      .rd_valid_o (tbl_valid),
      .rd_ep_id_o (tbl_ep_id)
   );

   assign req_ready = !rst && (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_hit   = hit_q;
   assign rsp_slot  = slot_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ep_d    = ep_q;
      hit_d   = hit_q;
      slot_d  = slot_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               ep_d    = req_ep_id;
               idx_d   = '0;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (tbl_valid && (tbl_ep_id == ep_q)) begin
               hit_d   = 1'b1;
               slot_d  = idx_q;
               state_d = ST_RESP;
            end else if (idx_q == LAST_IDX) begin
               hit_d   = 1'b0;
               slot_d  = '0;
               state_d = ST_RESP;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         // Handshake returns to IDLE; a new request waits for the next cycle.
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         ep_q    <= '0;
         hit_q   <= 1'b0;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ep_q    <= ep_d;
         hit_q   <= hit_d;
         slot_q  <= slot_d;
      end
   end

endmodule

// File: tb/tb_smc_slot_responder.sv
// Scoreboard bench for smc_slot_responder: driver pushes expected results,
// a negedge monitor pops and checks hit, slot, latency and hold stability.
module tb_smc_slot_responder;

   localparam int NS = 16;
   localparam int EW = 8;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [EW-1:0] req_ep_id = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic          rsp_hit;
   logic [IW-1:0] rsp_slot;
   logic          cfg_we = 1'b0;
   logic [IW-1:0] cfg_slot = '0;
   logic [EW-1:0] cfg_ep_id = '0;
   logic          cfg_valid = 1'b0;

   smc_slot_responder #(.NUM_SLOTS(NS), .EP_W(EW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_ep_id (req_ep_id),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_hit   (rsp_hit),
      .rsp_slot  (rsp_slot),
      .cfg_we    (cfg_we),
      .cfg_slot  (cfg_slot),
      .cfg_ep_id (cfg_ep_id),
      .cfg_valid (cfg_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic          hit;
      logic [IW-1:0] slot;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_wr(input logic [IW-1:0] s, input logic v, input logic [EW-1:0] ep);
      cfg_we    = 1'b1;
      cfg_slot  = s;
      cfg_valid = v;
      cfg_ep_id = ep;
      tick();
      cfg_we    = 1'b0;
   endtask

   // lat: cycles from the accept cycle to the first rsp_valid cycle; lat<0 means no response expected.
   task automatic issue(input logic [EW-1:0] ep, input logic hit, input logic [IW-1:0] slot,
                        input int lat);
      exp_t e;
      for (int n = 0; n < 50 && !req_ready; n++) tick();
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_ep_id = ep;
      if (lat >= 0) begin
         e.hit  = hit;
         e.slot = slot;
         e.cyc  = cyc + lat;
         sb.push_back(e);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      for (n = 0; n < 100 && !rsp_valid; n++) tick();
      if (!rsp_valid) chk("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
   endtask

   task automatic wait_done();
      wait_valid();
      if (rsp_valid && rsp_ready) begin
         tick();
         chk("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
         chk("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
      end
   endtask

   // Monitor
   logic          pv = 1'b0, pr = 1'b0, ph = 1'b0;
   logic [IW-1:0] ps = '0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 1'b0;
         end else begin
            if (rsp_valid && !pv) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_rsp: rsp_valid=1 with nothing expected (cycle %0d)", cyc);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_hit", {31'd0, rsp_hit}, {31'd0, e.hit});
                  chk("rsp_slot", {28'd0, rsp_slot}, {28'd0, e.slot});
                  chk("rsp_cycle", cyc, e.cyc);
                  chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
               end
            end else if (rsp_valid && pv) begin
               if (pr) begin
                  chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
               end else begin
                  chk("rsp_hit_stable", {31'd0, rsp_hit}, {31'd0, ph});
                  chk("rsp_slot_stable", {28'd0, rsp_slot}, {28'd0, ps});
                  chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
               end
            end
            pv = rsp_valid;
            pr = rsp_ready;
            ph = rsp_hit;
            ps = rsp_slot;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. Reset then idle
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("req_ready_rst", {31'd0, req_ready}, 32'd0);
         chk("rsp_valid_rst", {31'd0, rsp_valid}, 32'd0);
      end
      chk("rsp_hit_rst", {31'd0, rsp_hit}, 32'd0);
      chk("rsp_slot_rst", {28'd0, rsp_slot}, 32'd0);
      rst = 1'b0;
      tick();
      chk("req_ready_post_rst", {31'd0, req_ready}, 32'd1);

      // 2. Hit at slot 5
      cfg_wr(4'd5, 1'b1, 8'h3A);
      issue(8'h3A, 1'b1, 4'd5, 7);
      wait_done();

      // 4. Duplicates: lowest index wins
      cfg_wr(4'd2, 1'b1, 8'h07);
      cfg_wr(4'd9, 1'b1, 8'h07);
      issue(8'h07, 1'b1, 4'd2, 4);
      wait_done();

      // 3. Miss with backpressure
      rsp_ready = 1'b0;
      issue(8'h11, 1'b0, 4'd0, NS + 1);
      wait_valid();
      for (int i = 0; i < 4; i++) tick();
      chk("req_ready_bp", {31'd0, req_ready}, 32'd0);
      rsp_ready = 1'b1;
      wait_done();

      // 5a. Write an unscanned slot during scan -> seen
      issue(8'h44, 1'b1, 4'd10, 12);
      for (int i = 0; i < 3; i++) tick();
      cfg_wr(4'd10, 1'b1, 8'h44);
      wait_done();
      cfg_wr(4'd10, 1'b0, 8'h00);

      // 5b. Write the slot being compared -> old value used, miss
      issue(8'h44, 1'b0, 4'd0, NS + 1);
      for (int i = 0; i < 3; i++) tick();
      cfg_wr(4'd3, 1'b1, 8'h44);
      wait_done();

      // 6. Reset mid-scan drops the transaction and clears the table
      cfg_wr(4'd12, 1'b1, 8'h55);
      issue(8'h55, 1'b1, 4'd12, -1);
      for (int i = 0; i < 6; i++) tick();
      rst = 1'b1;
      tick();
      chk("req_ready_mid_rst", {31'd0, req_ready}, 32'd0);
      chk("rsp_valid_mid_rst", {31'd0, rsp_valid}, 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      issue(8'h55, 1'b0, 4'd0, NS + 1);
      wait_done();
      issue(8'h44, 1'b0, 4'd0, NS + 1);
      wait_done();

      tick();
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
